// File: rtl/clk_div_if.sv
// Handshake and output bundle for the programmable clock divider.
interface clk_div_if #(
    parameter int DIV_W = 8
);
    logic             en;
    logic             div_req;
    logic [DIV_W-1:0] div_val;
    logic             div_ack;
    logic             div_err;
    logic             div_busy;
    logic [DIV_W-1:0] cur_div;
    logic             tick;
    logic             clk_out;

    modport master (
        output en, div_req, div_val,
        input  div_ack, div_err, div_busy, cur_div, tick, clk_out
    );

    modport slave (
        input  en, div_req, div_val,
        output div_ack, div_err, div_busy, cur_div, tick, clk_out
    );
endinterface

// File: rtl/clk_div_sched.sv
// Run-time programmable 50%-duty clock divider; ratio changes land only on a period boundary.
// Outputs registered (clk_out one posedge/negedge deep); one request outstanding, extras ignored while busy.
module clk_div_sched #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 5
) (
    input  logic       clk,
    input  logic       rst,
    clk_div_if.slave   bus
);
    typedef enum logic [1:0] {STOP, RUN, PEND} state_t;

    state_t           state, state_nx;
    logic [DIV_W-1:0] cnt, cnt_nx;
    logic [DIV_W-1:0] cur_div, cur_div_nx;
    logic [DIV_W-1:0] pend_div, pend_div_nx;
    logic             pos_q, pos_nx;
    logic             neg_q;
    logic             ack_q, ack_nx;
    logic             err_q, err_nx;
    logic             busy_q, busy_nx;
    logic             tick_q, tick_nx;
    logic             wrap;
    logic             accept;
    logic             run_nx;
    logic [DIV_W:0]   half_nx;

    assign wrap = (cnt == cur_div - DIV_W'(1));

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        cur_div_nx  = cur_div;
        pend_div_nx = pend_div;
        busy_nx     = busy_q;
        ack_nx      = 1'b0;
        err_nx      = 1'b0;
        accept      = 1'b0;

        if (bus.div_req && !busy_q) begin
            if (bus.div_val > DIV_W'(1)) begin
                accept      = 1'b1;
                pend_div_nx = bus.div_val;
                busy_nx     = 1'b1;
            end else begin
                err_nx = 1'b1;
            end
        end

        case (state)
            STOP: begin
                cnt_nx = '0;
                // Stopped: nothing to protect, so a pending ratio lands at once.
                if (busy_q) begin
                    cur_div_nx = pend_div;
                    ack_nx     = 1'b1;
                    busy_nx    = 1'b0;
                end
                if (bus.en) state_nx = accept ? PEND : RUN;
            end
            RUN: begin
                cnt_nx = wrap ? '0 : cnt + 1'b1;
                if (wrap && !bus.en) state_nx = STOP;
                else if (accept)     state_nx = PEND;
            end
            PEND: begin
                cnt_nx = wrap ? '0 : cnt + 1'b1;
                if (wrap) begin
                    cur_div_nx = pend_div;
                    ack_nx     = 1'b1;
                    busy_nx    = 1'b0;
                    state_nx   = bus.en ? RUN : STOP;
                end
            end
            default: state_nx = STOP;
        endcase

        // High phase covers the first ceil(N/2) counts; the negedge copy trims odd N by half a cycle.
        run_nx  = (state_nx != STOP);
        half_nx = ({1'b0, cur_div_nx} + 1'b1) >> 1;
        tick_nx = run_nx && (cnt_nx == '0);
        pos_nx  = run_nx && ({1'b0, cnt_nx} < half_nx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= STOP;
            cnt      <= '0;
            cur_div  <= DIV_W'(DEFAULT_DIV);
            pend_div <= '0;
            pos_q    <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            cur_div  <= cur_div_nx;
            pend_div <= pend_div_nx;
            pos_q    <= pos_nx;
            ack_q    <= ack_nx;
            err_q    <= err_nx;
            busy_q   <= busy_nx;
            tick_q   <= tick_nx;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) neg_q <= 1'b0;
        else     neg_q <= pos_q;
    end

    assign bus.clk_out  = cur_div[0] ? (pos_q & neg_q) : pos_q;
    assign bus.div_ack  = ack_q;
    assign bus.div_err  = err_q;
    assign bus.div_busy = busy_q;
    assign bus.cur_div  = cur_div;
    assign bus.tick     = tick_q;
endmodule
